accel_fifo_bridge: RTL and testbench

Accelerator-side endpoint of the controller's FIFO handshake, one instance per accelerator (FFT, FIR, IIR). Holds an inbound FIFO the controller writes with `put_req` and an outbound FIFO the controller reads with `get_req`. It reports `to_*`/`from_*` empty/full flags back to the controller. The accelerator core pops inbound words and pushes results on a simple valid/ready side.

---
 rtl/accel_fifo_bridge.sv | 129 ++++++++++++
 tb/tb_accel_fifo_bridge.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_fifo_bridge.sv
// Accelerator-side FIFO bridge: inbound FIFO (controller put -> accelerator pop) and outbound FIFO
// (accelerator push -> controller get). Define ACCEL_FIFO_BRIDGE_ERR_EN to add the sticky err output.
module accel_fifo_bridge #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             put_req,
    input  logic [WIDTH-1:0] data_in,
    output logic             to_empty,
    output logic             to_full,
    input  logic             get_req,
    output logic [WIDTH-1:0] data_out,
    output logic             from_empty,
    output logic             from_full,
    output logic [WIDTH-1:0] acc_in_data,
    output logic             acc_in_valid,
    input  logic             acc_in_pop,
    input  logic [WIDTH-1:0] acc_out_data,
    input  logic             acc_out_push,
    output logic             acc_out_ready
`ifdef ACCEL_FIFO_BRIDGE_ERR_EN
    ,
    output logic             err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] in_mem  [DEPTH];
    logic [WIDTH-1:0] out_mem [DEPTH];

    logic [AW-1:0]    in_wr_ptr_reg, in_rd_ptr_reg;
    logic [AW:0]      in_count_reg, in_count_next;
    logic [AW-1:0]    out_wr_ptr_reg, out_rd_ptr_reg;
    logic [AW:0]      out_count_reg, out_count_next;
    logic [WIDTH-1:0] data_out_reg;

    logic in_wr_en, in_rd_en, out_wr_en, out_rd_en;

    // Flags come only from registered counts, so every accept decision uses pre-edge state.
    assign to_empty   = (in_count_reg == '0);
    assign to_full    = (in_count_reg == FULL_COUNT);
    assign from_empty = (out_count_reg == '0);
    assign from_full  = (out_count_reg == FULL_COUNT);

    assign in_wr_en  = put_req && !to_full;
    assign in_rd_en  = acc_in_pop && !to_empty;
    assign out_wr_en = acc_out_push && !from_full;
    assign out_rd_en = get_req && !from_empty;

    assign acc_in_valid  = !to_empty;
    assign acc_out_ready = !from_full;
    assign acc_in_data   = in_mem[in_rd_ptr_reg];
    assign data_out      = data_out_reg;

    always_comb begin
        in_count_next = in_count_reg;
        if (in_wr_en && !in_rd_en) begin
            in_count_next = in_count_reg + (AW+1)'(1);
        end else if (!in_wr_en && in_rd_en) begin
            in_count_next = in_count_reg - (AW+1)'(1);
        end
    end

    always_comb begin
        out_count_next = out_count_reg;
        if (out_wr_en && !out_rd_en) begin
            out_count_next = out_count_reg + (AW+1)'(1);
        end else if (!out_wr_en && out_rd_en) begin
            out_count_next = out_count_reg - (AW+1)'(1);
        end
    end

    // Storage is deliberately left out of reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (in_wr_en) begin
            in_mem[in_wr_ptr_reg] <= data_in;
        end
        if (out_wr_en) begin
            out_mem[out_wr_ptr_reg] <= acc_out_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_wr_ptr_reg  <= '0;
            in_rd_ptr_reg  <= '0;
            in_count_reg   <= '0;
            out_wr_ptr_reg <= '0;
            out_rd_ptr_reg <= '0;
            out_count_reg  <= '0;
            data_out_reg   <= '0;
        end else begin
            in_count_reg  <= in_count_next;
            out_count_reg <= out_count_next;
            if (in_wr_en) begin
                in_wr_ptr_reg <= in_wr_ptr_reg + AW'(1);
            end
            if (in_rd_en) begin
                in_rd_ptr_reg <= in_rd_ptr_reg + AW'(1);
            end
            if (out_wr_en) begin
                out_wr_ptr_reg <= out_wr_ptr_reg + AW'(1);
            end
            if (out_rd_en) begin
                out_rd_ptr_reg <= out_rd_ptr_reg + AW'(1);
                data_out_reg   <= out_mem[out_rd_ptr_reg];
            end
        end
    end

`ifdef ACCEL_FIFO_BRIDGE_ERR_EN
    logic err_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_reg <= 1'b0;
        end else if ((put_req && to_full) || (get_req && from_empty)) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`endif

endmodule

// File: tb/tb_accel_fifo_bridge.sv
// Directed testbench for accel_fifo_bridge (DEPTH=16, WIDTH=32); checks the err output when
// ACCEL_FIFO_BRIDGE_ERR_EN is defined.
module tb_accel_fifo_bridge;

    logic        clk;
    logic        reset;
    logic        put_req;
    logic [31:0] data_in;
    logic        to_empty, to_full;
    logic        get_req;
    logic [31:0] data_out;
    logic        from_empty, from_full;
    logic [31:0] acc_in_data;
    logic        acc_in_valid;
    logic        acc_in_pop;
    logic [31:0] acc_out_data;
    logic        acc_out_push;
    logic        acc_out_ready;
`ifdef ACCEL_FIFO_BRIDGE_ERR_EN
    logic        err;
`endif

    int total = 0;
    int bad   = 0;

    accel_fifo_bridge #(.DEPTH(16), .WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .put_req      (put_req),
        .data_in      (data_in),
        .to_empty     (to_empty),
        .to_full      (to_full),
        .get_req      (get_req),
        .data_out     (data_out),
        .from_empty   (from_empty),
        .from_full    (from_full),
        .acc_in_data  (acc_in_data),
        .acc_in_valid (acc_in_valid),
        .acc_in_pop   (acc_in_pop),
        .acc_out_data (acc_out_data),
        .acc_out_push (acc_out_push),
        .acc_out_ready(acc_out_ready)
`ifdef ACCEL_FIFO_BRIDGE_ERR_EN
        ,
        .err          (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        total++; if (to_empty !== 1'b1) begin bad++; $display("FAIL reset_to_empty got=%b exp=1", to_empty); end
        total++; if (from_empty !== 1'b1) begin bad++; $display("FAIL reset_from_empty got=%b exp=1", from_empty); end
        total++; if (to_full !== 1'b0) begin bad++; $display("FAIL reset_to_full got=%b exp=0", to_full); end
        total++; if (from_full !== 1'b0) begin bad++; $display("FAIL reset_from_full got=%b exp=0", from_full); end
        total++; if (data_out !== 32'h0) begin bad++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
        total++; if (acc_out_ready !== 1'b1) begin bad++; $display("FAIL reset_acc_out_ready got=%b exp=1", acc_out_ready); end
        total++; if (acc_in_valid !== 1'b0) begin bad++; $display("FAIL reset_acc_in_valid got=%b exp=0", acc_in_valid); end
        $display("reset: to_empty=%b from_empty=%b data_out=%h", to_empty, from_empty, data_out);
    endtask

`ifdef ACCEL_FIFO_BRIDGE_ERR_EN
    task automatic test_err;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_initial got=%b exp=0", err); end
        get_req = 1'b1;
        step;
        get_req = 1'b0;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_get_empty got=%b exp=1", err); end
        total++; if (data_out !== 32'h0) begin bad++; $display("FAIL err_data_hold got=%h exp=0", data_out); end
        acc_out_push = 1'b1; acc_out_data = 32'h0000_BEEF;
        step;
        acc_out_push = 1'b0;
        get_req = 1'b1;
        step;
        get_req = 1'b0;
        total++; if (data_out !== 32'h0000_BEEF) begin bad++; $display("FAIL err_traffic_data got=%h exp=0000beef", data_out); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err); end
        $display("err: err=%b data_out=%h", err, data_out);
    endtask
`endif

    task automatic test_inbound_fill;
        for (int i = 1; i <= 16; i++) begin
            put_req = 1'b1; data_in = 32'(i);
            step;
            total++; if (acc_in_valid !== 1'b1) begin bad++; $display("FAIL fill_valid_%0d got=%b exp=1", i, acc_in_valid); end
            total++; if (to_full !== (i == 16)) begin bad++; $display("FAIL fill_full_%0d got=%b exp=%b", i, to_full, (i == 16)); end
        end
        data_in = 32'h0000_DEAD;
        step;
        put_req = 1'b0;
        total++; if (to_full !== 1'b1) begin bad++; $display("FAIL fill_drop_full got=%b exp=1", to_full); end
        for (int i = 1; i <= 16; i++) begin
            total++; if (acc_in_data !== 32'(i)) begin bad++; $display("FAIL drain_data_%0d got=%h exp=%h", i, acc_in_data, 32'(i)); end
            $display("pop: acc_in_data=%h", acc_in_data);
            acc_in_pop = 1'b1;
            step;
        end
        acc_in_pop = 1'b0;
        total++; if (to_empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", to_empty); end
        total++; if (acc_in_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b exp=0", acc_in_valid); end
        // A pop while empty must not disturb the next word written.
        acc_in_pop = 1'b1;
        step;
        acc_in_pop = 1'b0;
        put_req = 1'b1; data_in = 32'h0000_0077;
        step;
        put_req = 1'b0;
        total++; if (acc_in_data !== 32'h0000_0077) begin bad++; $display("FAIL pop_empty_data got=%h exp=00000077", acc_in_data); end
        acc_in_pop = 1'b1;
        step;
        acc_in_pop = 1'b0;
        total++; if (to_empty !== 1'b1) begin bad++; $display("FAIL pop_empty_after got=%b exp=1", to_empty); end
    endtask

    task automatic test_put_full_with_pop;
        put_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            data_in = 32'h200 + 32'(i);
            step;
        end
        // Full: put and pop together, the put is dropped.
        data_in = 32'h0000_0BAD; acc_in_pop = 1'b1;
        step;
        put_req = 1'b0; acc_in_pop = 1'b0;
        total++; if (to_full !== 1'b0) begin bad++; $display("FAIL fullpop_full got=%b exp=0", to_full); end
        for (int i = 1; i < 16; i++) begin
            total++; if (acc_in_data !== 32'h200 + 32'(i)) begin bad++; $display("FAIL fullpop_data_%0d got=%h exp=%h", i, acc_in_data, 32'h200 + 32'(i)); end
            acc_in_pop = 1'b1;
            step;
        end
        acc_in_pop = 1'b0;
        total++; if (to_empty !== 1'b1) begin bad++; $display("FAIL fullpop_empty got=%b exp=1", to_empty); end
    endtask

    task automatic test_outbound;
        acc_out_push = 1'b1; acc_out_data = 32'hA5A5_0001;
        step;
        acc_out_data = 32'hA5A5_0002;
        step;
        acc_out_push = 1'b0;
        total++; if (from_empty !== 1'b0) begin bad++; $display("FAIL out_not_empty got=%b exp=0", from_empty); end
        get_req = 1'b1;
        step;
        $display("get: data_out=%h", data_out);
        total++; if (data_out !== 32'hA5A5_0001) begin bad++; $display("FAIL out_get1 got=%h exp=a5a50001", data_out); end
        step;
        $display("get: data_out=%h", data_out);
        total++; if (data_out !== 32'hA5A5_0002) begin bad++; $display("FAIL out_get2 got=%h exp=a5a50002", data_out); end
        step;
        $display("get: data_out=%h", data_out);
        total++; if (data_out !== 32'hA5A5_0002) begin bad++; $display("FAIL out_get3_hold got=%h exp=a5a50002", data_out); end
        total++; if (from_empty !== 1'b1) begin bad++; $display("FAIL out_empty got=%b exp=1", from_empty); end
        // Get while empty with a same-cycle push: get ignored, word still queued.
        acc_out_push = 1'b1; acc_out_data = 32'hA5A5_0003;
        step;
        acc_out_push = 1'b0;
        total++; if (data_out !== 32'hA5A5_0002) begin bad++; $display("FAIL out_get_push_hold got=%h exp=a5a50002", data_out); end
        total++; if (from_empty !== 1'b0) begin bad++; $display("FAIL out_get_push_queued got=%b exp=0", from_empty); end
        step;
        get_req = 1'b0;
        total++; if (data_out !== 32'hA5A5_0003) begin bad++; $display("FAIL out_get4 got=%h exp=a5a50003", data_out); end
        // Fill to full, drop one push, drain in order.
        acc_out_push = 1'b1;
        for (int i = 0; i < 16; i++) begin
            acc_out_data = 32'hC000_0000 + 32'(i);
            step;
        end
        total++; if (from_full !== 1'b1) begin bad++; $display("FAIL out_full got=%b exp=1", from_full); end
        total++; if (acc_out_ready !== 1'b0) begin bad++; $display("FAIL out_ready got=%b exp=0", acc_out_ready); end
        acc_out_data = 32'hDEAD_DEAD;
        step;
        acc_out_push = 1'b0;
        get_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step;
            total++; if (data_out !== 32'hC000_0000 + 32'(i)) begin bad++; $display("FAIL out_drain_%0d got=%h exp=%h", i, data_out, 32'hC000_0000 + 32'(i)); end
        end
        get_req = 1'b0;
        total++; if (from_empty !== 1'b1) begin bad++; $display("FAIL out_drain_empty got=%b exp=1", from_empty); end
    endtask

    task automatic test_wrap;
        put_req = 1'b1;
        for (int i = 0; i < 15; i++) begin
            data_in = 32'h100 + 32'(i);
            step;
        end
        acc_in_pop = 1'b1;
        for (int c = 0; c < 40; c++) begin
            data_in = 32'h100 + 32'(15 + c);
            total++; if (acc_in_data !== 32'h100 + 32'(c)) begin bad++; $display("FAIL wrap_data_%0d got=%h exp=%h", c, acc_in_data, 32'h100 + 32'(c)); end
            step;
            total++; if (to_full !== 1'b0 || to_empty !== 1'b0) begin bad++; $display("FAIL wrap_flags_%0d got=%b%b exp=00", c, to_full, to_empty); end
        end
        put_req = 1'b0;
        for (int i = 0; i < 15; i++) begin
            total++; if (acc_in_data !== 32'h100 + 32'(40 + i)) begin bad++; $display("FAIL wrap_drain_%0d got=%h exp=%h", i, acc_in_data, 32'h100 + 32'(40 + i)); end
            step;
        end
        acc_in_pop = 1'b0;
        total++; if (to_empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b exp=1", to_empty); end
    endtask

    task automatic test_mid_reset;
        put_req = 1'b1; acc_out_push = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_in = 32'h300 + 32'(i);
            acc_out_data = 32'h400 + 32'(i);
            step;
        end
        put_req = 1'b0; acc_out_push = 1'b0;
        get_req = 1'b1;
        step;
        get_req = 1'b0;
        total++; if (data_out !== 32'h400) begin bad++; $display("FAIL mid_pre_data got=%h exp=00000400", data_out); end
        // Half-cycle low pulse between rising edges.
        reset = 1'b0;
        #2;
        total++; if (to_empty !== 1'b1) begin bad++; $display("FAIL mid_to_empty got=%b exp=1", to_empty); end
        total++; if (from_empty !== 1'b1) begin bad++; $display("FAIL mid_from_empty got=%b exp=1", from_empty); end
        total++; if (data_out !== 32'h0) begin bad++; $display("FAIL mid_data_out got=%h exp=0", data_out); end
        total++; if (acc_out_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", acc_out_ready); end
`ifdef ACCEL_FIFO_BRIDGE_ERR_EN
        total++; if (err !== 1'b0) begin bad++; $display("FAIL mid_err got=%b exp=0", err); end
`endif
        #3;
        reset = 1'b1;
        step;
        put_req = 1'b1; data_in = 32'h0000_0555;
        step;
        put_req = 1'b0;
        total++; if (acc_in_data !== 32'h0000_0555 || acc_in_valid !== 1'b1) begin bad++; $display("FAIL mid_after_put got=%h/%b exp=00000555/1", acc_in_data, acc_in_valid); end
        total++; if (from_empty !== 1'b1) begin bad++; $display("FAIL mid_after_from_empty got=%b exp=1", from_empty); end
        $display("mid_reset: to_empty=%b from_empty=%b data_out=%h", to_empty, from_empty, data_out);
    endtask

    initial begin
        reset = 1'b0; put_req = 1'b0; data_in = '0; get_req = 1'b0;
        acc_in_pop = 1'b0; acc_out_data = '0; acc_out_push = 1'b0;
        step;
        step;
        reset = 1'b1;
        step;
        test_reset;
`ifdef ACCEL_FIFO_BRIDGE_ERR_EN
        test_err;
`endif
        test_inbound_fill;
        test_put_full_with_pop;
        test_outbound;
        test_wrap;
        test_mid_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
